// File: rtl/mod_arith_pipe.sv
// Elastic multi-lane modular arithmetic pipeline (mul/add/sub/pass mod Q) with Barrett reduction.
// Handshake: a beat moves on in_valid && in_ready; a result drains on out_valid && out_ready;
// all five register stages advance together when adv = !out_valid || out_ready, otherwise hold.
module mod_arith_pipe #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_res,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int XW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;
  localparam logic [XW:0]   P2X   = {1'b1, {XW{1'b0}}};
  localparam logic [XW:0]   M_EXT = P2X / (XW+1)'(Q);
  localparam logic [XW-1:0] M     = M_EXT[XW-1:0];
  localparam logic [XW-1:0] QX    = XW'(Q);
  localparam int            K     = ((1 << WIDTH) + Q - 1) / Q;
  localparam logic [XW-1:0] KQ    = XW'(K * Q);
  localparam logic [RW-1:0] QR    = RW'(Q);

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // Adding K*Q keeps the subtraction non-negative for any WIDTH-bit b.
  function automatic logic [XW-1:0] form_x(input logic [1:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [XW-1:0] x;
    x = '0;
    case (op_e'(op))
      OP_MUL:  x = XW'(a) * XW'(b);
      OP_ADD:  x = XW'(a) + XW'(b);
      OP_SUB:  x = XW'(a) + KQ - XW'(b);
      OP_PASS: x = XW'(a);
      default: x = '0;
    endcase
    return x;
  endfunction

  function automatic logic [XW-1:0] barrett_q(input logic [XW-1:0] x);
    logic [2*XW-1:0] p;
    p = {{XW{1'b0}}, x} * {{XW{1'b0}}, M};
    return XW'(p >> XW);
  endfunction

  // q_est undershoots by at most 2, so r < 3Q and two corrections suffice.
  function automatic logic [WIDTH-1:0] reduce(input logic [XW-1:0] x,
                                              input logic [XW-1:0] qe);
    logic [RW-1:0] r;
    r = RW'(x - qe * QX);
    if (r >= QR) r = r - QR;
    if (r >= QR) r = r - QR;
    return WIDTH'(r);
  endfunction

  logic                   s0_valid_q, s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
  logic [1:0]             s0_op_q;
  logic [LANES*WIDTH-1:0] s0_a_q, s0_b_q;
  logic [TAG_W-1:0]       s0_tag_q, s1_tag_q, s2_tag_q, s3_tag_q, s4_tag_q;
  logic [XW-1:0]          s1_x_q  [LANES];
  logic [XW-1:0]          s2_x_q  [LANES];
  logic [XW-1:0]          s2_qe_q [LANES];
  logic [LANES*WIDTH-1:0] s3_res_q, s4_res_q;

  logic [XW-1:0]          s1_x_d  [LANES];
  logic [XW-1:0]          s2_qe_d [LANES];
  logic [LANES*WIDTH-1:0] s3_res_d;
  logic                   adv;

  assign adv       = !s4_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = s4_valid_q;
  assign out_res   = s4_res_q;
  assign out_tag   = s4_tag_q;

  always_comb begin
    s3_res_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_x_d[i]  = form_x(s0_op_q, s0_a_q[i*WIDTH +: WIDTH], s0_b_q[i*WIDTH +: WIDTH]);
      s2_qe_d[i] = barrett_q(s1_x_q[i]);
      s3_res_d[i*WIDTH +: WIDTH] = reduce(s2_x_q[i], s2_qe_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s4_valid_q <= 1'b0;
      s0_op_q    <= 2'b00;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_tag_q   <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
      s4_tag_q   <= '0;
      s3_res_q   <= '0;
      s4_res_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_x_q[i]  <= '0;
        s2_x_q[i]  <= '0;
        s2_qe_q[i] <= '0;
      end
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_op_q    <= in_op;
      s0_a_q     <= in_a;
      s0_b_q     <= in_b;
      s0_tag_q   <= in_tag;

      s1_valid_q <= s0_valid_q;
      s1_tag_q   <= s0_tag_q;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      for (int i = 0; i < LANES; i++) begin
        s1_x_q[i]  <= s1_x_d[i];
        s2_x_q[i]  <= s1_x_q[i];
        s2_qe_q[i] <= s2_qe_d[i];
      end

      s3_valid_q <= s2_valid_q;
      s3_tag_q   <= s2_tag_q;
      s3_res_q   <= s3_res_d;

      s4_valid_q <= s3_valid_q;
      s4_tag_q   <= s3_tag_q;
      s4_res_q   <= s3_res_q;
    end
  end

endmodule

// File: tb/tb_mod_arith_pipe.sv
// Bench for mod_arith_pipe: directed boundary beats, streaming, backpressure, mid-flight reset
// and a long random regression, all scored against a plain-arithmetic modular model.
module tb_mod_arith_pipe;

  localparam int W    = 12;
  localparam int Q    = 3329;
  localparam int L    = 4;
  localparam int TW   = 4;
  localparam int RESW = L * W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [RESW-1:0] in_a, in_b;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [RESW-1:0] out_res;
  logic [TW-1:0]   out_tag;

  mod_arith_pipe #(.WIDTH(W), .Q(Q), .LANES(L), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_lane(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'b00:   r = (a * b) % Q;
      2'b01:   r = (a + b) % Q;
      2'b10:   r = (((a - b) % Q) + Q) % Q;
      default: r = a % Q;
    endcase
    return W'(r);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [RESW+TW-1:0] exp_q[$];
  int                 acc_q[$];
  logic               lat_en = 1'b0;
  logic               prev_stall = 1'b0;
  logic [RESW-1:0]    prev_res;
  logic [TW-1:0]      prev_tag;
  logic [W-1:0]       last_res0 = '0;
  logic [TW-1:0]      last_tag = '0;
  logic [RESW+TW-1:0] e_item;
  logic [RESW-1:0]    er;
  int                 a_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_res", out_res, 0);
      check_val("rst_out_tag", out_tag, 0);
      check_val("rst_in_ready", in_ready, 1);
    end else begin
      check_val("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_res", out_res, prev_res);
        check_val("hold_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", out_valid, 0);
        end else begin
          e_item = exp_q.pop_front();
          a_c    = acc_q.pop_front();
          check_val("res", out_res, e_item[RESW-1:0]);
          check_val("tag", out_tag, e_item[RESW +: TW]);
          for (int i = 0; i < L; i++)
            check_val("lane_range", out_res[i*W +: W] < W'(Q), 1);
          if (lat_en) check_val("latency", cyc - a_c, 4);
          last_res0 = out_res[W-1:0];
          last_tag  = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < L; i++)
          er[i*W +: W] = model_lane(in_op, int'(in_a[i*W +: W]), int'(in_b[i*W +: W]));
        exp_q.push_back({in_tag, er});
        acc_q.push_back(cyc + 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_tag   = out_tag;
    end
  end

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;
  int rdy_phase = 0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [1:0] op, input logic [RESW-1:0] a,
                           input logic [RESW-1:0] b, input logic [TW-1:0] tag);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  function automatic logic [RESW-1:0] rand_lanes();
    logic [RESW-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom_range(0, 4095));
    return v;
  endfunction

  task automatic run_directed(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [TW-1:0] tag, input logic [W-1:0] exp_res);
    send_beat(op, {L{a}}, {L{b}}, tag);
    wait_drain();
    check_val("dir_res", last_res0, exp_res);
    check_val("dir_tag", last_tag, tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_a     = '1;
    in_b     = '1;
    in_tag   = '1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // directed reduced and unreduced operands
    lat_en = 1'b1;
    run_directed(2'b00, 12'd3328, 12'd3328, 4'd5, 12'd1);
    run_directed(2'b00, 12'd4095, 12'd4095, 4'd1, 12'd852);
    run_directed(2'b11, 12'd4095, 12'd0,    4'd2, 12'd766);
    run_directed(2'b01, 12'd3000, 12'd1000, 4'd3, 12'd671);
    run_directed(2'b10, 12'd5,    12'd10,   4'd4, 12'd3324);
    run_directed(2'b10, 12'd0,    12'd4095, 4'd6, 12'd2563);

    // back-to-back streaming, op cycling per beat
    for (int k = 0; k < 8; k++) send_beat(2'(k % 4), rand_lanes(), rand_lanes(), TW'(k));
    wait_drain();

    // backpressure with out_ready pattern 1,0,0
    lat_en    = 1'b0;
    rdy_phase = 0;
    rdy_mode  = 1;
    for (int k = 0; k < 40; k++) send_beat(2'($urandom_range(0, 3)), rand_lanes(), rand_lanes(), TW'(k));
    wait_drain();

    // reset while three beats are in flight
    rdy_mode = 0;
    idle(1);
    lat_en = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(2'b01, rand_lanes(), rand_lanes(), TW'(k + 8));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_val("rst_mid_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    run_directed(2'b00, 12'd3328, 12'd3328, 4'd5, 12'd1);

    // long random regression with random bubbles and random out_ready
    lat_en   = 1'b0;
    rdy_mode = 2;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_beat(2'($urandom_range(0, 3)), rand_lanes(), rand_lanes(), TW'($urandom_range(0, 15)));
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
